// File: rtl/dqs_burst_gen.sv
// DQS strobe generator for write bursts on one or more byte lanes.
// Each burst runs preamble (driven low), toggle, postamble (driven low),
// then releases the lanes. All strobe outputs are registered; only ready
// is decoded from state and counter.
module dqs_burst_gen #(
  parameter int LANES     = 2,
  parameter int PREAMBLE  = 1,
  parameter int POSTAMBLE = 1,
  parameter int BL_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BL_WIDTH-1:0] burst_len,
  input  logic [LANES-1:0]    lane_en,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [LANES-1:0]    dqs_data,
  output logic [LANES-1:0]    dqs_tri
);

  // One counter serves every phase, so it must hold both burst_len-1 and
  // the 4-bit preamble/postamble lengths.
  localparam int CW = (BL_WIDTH > 4) ? BL_WIDTH : 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_POST = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_next;
  logic [BL_WIDTH-1:0] r_bl;
  logic [BL_WIDTH-1:0] w_bl_next;
  logic [LANES-1:0]    r_lane;
  logic [LANES-1:0]    w_lane_next;
  logic                r_tog;
  logic                w_tog_next;
  logic                w_done_next;
  logic [LANES-1:0]    w_tri_next;
  logic [LANES-1:0]    w_data_next;
  logic                w_last;
  logic                w_accept;

  logic [LANES-1:0]    r_dqs_tri;
  logic [LANES-1:0]    r_dqs_data;
  logic                r_busy;
  logic                r_done;

  // The counter reaching zero marks the final cycle of the current phase.
  assign w_last   = (r_cnt == '0);
  assign ready    = (r_state == S_IDLE) || ((r_state == S_POST) && w_last);
  // A zero-length request carries no toggles, so it is dropped outright.
  assign w_accept = start && ready && (burst_len != '0);

  // State register, phase counter and per-burst latched request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bl    <= '0;
      r_lane  <= '0;
      r_tog   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bl    <= w_bl_next;
      r_lane  <= w_lane_next;
      r_tog   <= w_tog_next;
    end
  end

  // Next-state, counter reload on every phase entry, and done request.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bl_next    = r_bl;
    w_lane_next  = r_lane;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_PRE;
          w_cnt_next   = CW'(PREAMBLE - 1);
          w_bl_next    = burst_len;
          w_lane_next  = lane_en;
        end
      end
      S_PRE: begin
        if (w_last) begin
          w_state_next = S_DATA;
          w_cnt_next   = CW'(r_bl) - CW'(1);
        end else begin
          w_cnt_next   = r_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_state_next = S_POST;
          w_cnt_next   = CW'(POSTAMBLE - 1);
        end else begin
          w_cnt_next   = r_cnt - CW'(1);
        end
      end
      S_POST: begin
        if (w_last) begin
          w_done_next = 1'b1;
          if (w_accept) begin
            w_state_next = S_PRE;
            w_cnt_next   = CW'(PREAMBLE - 1);
            w_bl_next    = burst_len;
            w_lane_next  = lane_en;
          end else begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    w_tog_next  = 1'b0;
    w_tri_next  = '1;
    w_data_next = '0;
    if (w_state_next == S_DATA) begin
      w_tog_next = (r_state == S_DATA) ? ~r_tog : 1'b1;
    end
    if (w_state_next != S_IDLE) begin
      w_tri_next = ~w_lane_next;
    end
    if (w_state_next == S_DATA) begin
      w_data_next = w_lane_next & {LANES{w_tog_next}};
    end
  end

  // Registered strobe, status and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dqs_tri  <= '1;
      r_dqs_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_dqs_tri  <= w_tri_next;
      r_dqs_data <= w_data_next;
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= w_done_next;
    end
  end

  assign dqs_tri  = r_dqs_tri;
  assign dqs_data = r_dqs_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_dqs_burst_gen.sv
// Scoreboard bench for dqs_burst_gen: stimulus pushes hand-computed
// per-cycle expectations, a monitor pops and compares on each falling edge.
module tb_dqs_burst_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] burst_len;
  logic [1:0] lane_en;
  logic       ready;
  logic       busy;
  logic       done;
  logic [1:0] dqs_data;
  logic [1:0] dqs_tri;

  dqs_burst_gen #(
    .LANES(2), .PREAMBLE(1), .POSTAMBLE(1), .BL_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .lane_en(lane_en), .ready(ready), .busy(busy), .done(done),
    .dqs_data(dqs_data), .dqs_tri(dqs_tri)
  );

  typedef struct {
    int         c;
    logic [1:0] t;
    logic [1:0] d;
    logic       dn;
    logic       b;
    logic       r;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", nm, act, cyc);
    end
  endtask

  // Push an expectation for absolute cycle c (posedge count seen at the negedge).
  task automatic ex(input int c, input logic [1:0] t, input logic [1:0] d,
                    input logic dn, input logic b, input logic r, input string nm);
    exp_t e;
    e.c = c; e.t = t; e.d = d; e.dn = dn; e.b = b; e.r = r; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.c < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.nm, e.c, cyc);
      end else begin
        chk({e.nm, ".tri"},   {6'd0, dqs_tri},  {6'd0, e.t});
        chk({e.nm, ".data"},  {6'd0, dqs_data}, {6'd0, e.d});
        chk({e.nm, ".done"},  {7'd0, done},     {7'd0, e.dn});
        chk({e.nm, ".busy"},  {7'd0, busy},     {7'd0, e.b});
        chk({e.nm, ".ready"}, {7'd0, ready},    {7'd0, e.r});
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base;

  initial begin
    rst = 1'b1; start = 1'b0; burst_len = 4'd0; lane_en = 2'b00;
    // Reset with no clock running.
    #2;
    chk("rst.tri",   {6'd0, dqs_tri},  8'h03);
    chk("rst.data",  {6'd0, dqs_data}, 8'h00);
    chk("rst.ready", {7'd0, ready},    8'h01);
    chk("rst.busy",  {7'd0, busy},     8'h00);
    chk("rst.done",  {7'd0, done},     8'h00);
    #13 rst = 1'b0;
    wait_neg(2);

    // Single burst bl=4 lanes 11, with an ignored start during DATA.
    base = cyc;
    start = 1'b1; burst_len = 4'd4; lane_en = 2'b11;
    ex(base+1, 2'b00, 2'b00, 0, 1, 0, "s1.c1");
    ex(base+2, 2'b00, 2'b11, 0, 1, 0, "s1.c2");
    ex(base+3, 2'b00, 2'b00, 0, 1, 0, "s1.c3");
    ex(base+4, 2'b00, 2'b11, 0, 1, 0, "s1.c4");
    ex(base+5, 2'b00, 2'b00, 0, 1, 0, "s1.c5");
    ex(base+6, 2'b00, 2'b00, 0, 1, 1, "s1.c6");
    ex(base+7, 2'b11, 2'b00, 1, 0, 1, "s1.c7");
    ex(base+8, 2'b11, 2'b00, 0, 0, 1, "s1.c8");
    wait_neg(1); start = 1'b0;
    wait_neg(2); start = 1'b1; burst_len = 4'd4; lane_en = 2'b01;  // cycle 3
    wait_neg(1); start = 1'b0;
    wait_neg(6);

    // Lane mask bl=3 lanes 01.
    base = cyc;
    start = 1'b1; burst_len = 4'd3; lane_en = 2'b01;
    ex(base+1, 2'b10, 2'b00, 0, 1, 0, "s2.c1");
    ex(base+2, 2'b10, 2'b01, 0, 1, 0, "s2.c2");
    ex(base+3, 2'b10, 2'b00, 0, 1, 0, "s2.c3");
    ex(base+4, 2'b10, 2'b01, 0, 1, 0, "s2.c4");
    ex(base+5, 2'b10, 2'b00, 0, 1, 1, "s2.c5");
    ex(base+6, 2'b11, 2'b00, 1, 0, 1, "s2.c6");
    wait_neg(1); start = 1'b0;
    wait_neg(7);

    // Zero-length start is ignored.
    base = cyc;
    start = 1'b1; burst_len = 4'd0; lane_en = 2'b11;
    ex(base+1, 2'b11, 2'b00, 0, 0, 1, "s3.c1");
    ex(base+2, 2'b11, 2'b00, 0, 0, 1, "s3.c2");
    ex(base+3, 2'b11, 2'b00, 0, 0, 1, "s3.c3");
    wait_neg(1); start = 1'b0;
    wait_neg(4);

    // Back-to-back: bl=4 then bl=2 requested in the last POST cycle.
    base = cyc;
    start = 1'b1; burst_len = 4'd4; lane_en = 2'b11;
    ex(base+1,  2'b00, 2'b00, 0, 1, 0, "s4.c1");
    ex(base+2,  2'b00, 2'b11, 0, 1, 0, "s4.c2");
    ex(base+3,  2'b00, 2'b00, 0, 1, 0, "s4.c3");
    ex(base+4,  2'b00, 2'b11, 0, 1, 0, "s4.c4");
    ex(base+5,  2'b00, 2'b00, 0, 1, 0, "s4.c5");
    ex(base+6,  2'b00, 2'b00, 0, 1, 1, "s4.c6");
    ex(base+7,  2'b00, 2'b00, 1, 1, 0, "s4.c7");
    ex(base+8,  2'b00, 2'b11, 0, 1, 0, "s4.c8");
    ex(base+9,  2'b00, 2'b00, 0, 1, 0, "s4.c9");
    ex(base+10, 2'b00, 2'b00, 0, 1, 1, "s4.c10");
    ex(base+11, 2'b11, 2'b00, 1, 0, 1, "s4.c11");
    ex(base+12, 2'b11, 2'b00, 0, 0, 1, "s4.c12");
    wait_neg(1); start = 1'b0;
    wait_neg(5); start = 1'b1; burst_len = 4'd2; lane_en = 2'b11;  // cycle 6
    wait_neg(1); start = 1'b0;
    wait_neg(7);

    // Reset in the middle of DATA, then a fresh burst.
    base = cyc;
    start = 1'b1; burst_len = 4'd4; lane_en = 2'b11;
    ex(base+1, 2'b00, 2'b00, 0, 1, 0, "s5.c1");
    ex(base+2, 2'b00, 2'b11, 0, 1, 0, "s5.c2");
    ex(base+3, 2'b00, 2'b00, 0, 1, 0, "s5.c3");
    ex(base+4, 2'b11, 2'b00, 0, 0, 1, "s5.c4");
    ex(base+5, 2'b11, 2'b00, 0, 0, 1, "s5.c5");
    ex(base+6, 2'b11, 2'b00, 0, 0, 1, "s5.c6");
    ex(base+7, 2'b11, 2'b00, 0, 0, 1, "s5.c7");
    ex(base+8, 2'b11, 2'b00, 0, 0, 1, "s5.c8");
    wait_neg(1); start = 1'b0;
    wait_neg(2);  // in cycle 3, monitor has sampled
    #1 rst = 1'b1;
    #1;
    chk("s5.rst.tri",   {6'd0, dqs_tri}, 8'h03);
    chk("s5.rst.busy",  {7'd0, busy},    8'h00);
    chk("s5.rst.ready", {7'd0, ready},   8'h01);
    #1 rst = 1'b0;
    wait_neg(6);

    base = cyc;
    start = 1'b1; burst_len = 4'd1; lane_en = 2'b10;
    ex(base+1, 2'b01, 2'b00, 0, 1, 0, "s6.c1");
    ex(base+2, 2'b01, 2'b10, 0, 1, 0, "s6.c2");
    ex(base+3, 2'b01, 2'b00, 0, 1, 1, "s6.c3");
    ex(base+4, 2'b11, 2'b00, 1, 0, 1, "s6.c4");
    ex(base+5, 2'b11, 2'b00, 0, 0, 1, "s6.c5");
    wait_neg(1); start = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && q.size() > 0; i++) wait_neg(1);
    wait_neg(1);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
